coder_tb_scheduler: RTL and testbench
=====================================

Name: coder_tb_scheduler

Overview:
Admission controller and sequencer for the channel-coder stack (code-block segmentation → interleaver → turbo encoder). It accepts transport blocks (TBs) from upstream as a size descriptor followed by serial bits. It drives the stack's size and data write-request strobes and limits the number of TBs in flight with a credit counter. It also tracks completion by counting encoded code-block bursts on the stack's out_valid, and reports per-TB done and error events.

Parameters:
MAX_OUT, 2, maximum TBs in flight (1..3); also the depth of the completion descriptor FIFO
MIN_TB, 40, smallest legal TB size in bits
MAX_TB, 60000, largest legal TB size in bits
CB_MAX, 6144, largest code-block size K
CB_PAY, 6120, per-code-block payload used when segmenting (CB_MAX − 24)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
up_size_valid  in  1  TB size descriptor valid
up_size  in  16  TB size in bits
up_size_ready  out  1  descriptor accepted when valid & ready
up_bit  in  1  TB data bit
up_bit_valid  in  1  data bit valid
up_bit_ready  out  1  data bit accepted when valid & ready
cs_tb_size  out  16  size to the coder stack; registered and stable from SIZE until the next accepted descriptor
cs_wreq_size  out  1  one-cycle size write strobe to the coder stack
cs_tb_in  out  1  data bit to the coder stack
cs_wreq_data  out  1  data write strobe to the coder stack
cs_out_valid  in  1  encoder output-valid (one high burst per code block)
tb_done  out  1  one-cycle pulse when all code blocks of the oldest TB have been emitted
tb_err  out  1  one-cycle pulse when a descriptor is rejected
stray_err  out  1  sticky flag: a code-block burst ended with no TB outstanding
outstanding  out  2  current number of TBs in flight
busy  out  1  high when state ≠ IDLE or outstanding ≠ 0

Behaviour:
- Reset (reset = 0, async): state = IDLE; descriptor FIFO emptied; all counters cleared. All outputs 0, including cs_tb_size and stray_err.
- Reset mid-TB: the partial TB is abandoned, with no tb_done and no tb_err. Upstream must restart.
- State machine, admission side: IDLE → CALC → SIZE → DATA → IDLE.
- IDLE:
  - up_size_ready = (outstanding < MAX_OUT).
  - On handshake: if up_size < MIN_TB or up_size > MAX_TB, pulse tb_err next cycle and stay in IDLE. No push, no credit taken.
  - Otherwise register the size and go to CALC.
- CALC: compute the code-block count C from B = size + 24.
  - If B ≤ CB_MAX, C = 1; otherwise C = ceil(B / CB_PAY).
  - Computed by iterative subtraction, exactly C cycles in CALC; no divider.
  - Width: B held in 17 bits; C ≤ 10 fits 4 bits.
- SIZE (1 cycle):
  - cs_wreq_size = 1 and cs_tb_size = the registered size.
  - Push C into the descriptor FIFO and increment outstanding.
  - Bit counter = size. Next state: DATA.
- DATA:
  - up_bit_ready = 1.
  - Combinational pass-through: cs_tb_in = up_bit, cs_wreq_data = up_bit_valid.
  - Bit counter decrements per accepted bit. After the last bit is accepted, go to IDLE the next cycle.
  - Upstream stalls (up_bit_valid = 0) are allowed; no timeout.
- up_bit_ready = 0 and cs_wreq_data = 0 outside DATA.
- Latency: descriptor accepted in cycle N → cs_wreq_size high in cycle N+1+C → first bit accepted no earlier than N+2+C.
- Completion side (runs concurrently):
  - Register cs_out_valid; a burst end is a 1 → 0 transition.
  - On a burst end with the FIFO non-empty, increment the block counter.
  - When the block counter reaches the head C: pulse tb_done in the same cycle as that edge detection, pop the FIFO, clear the block counter, and decrement outstanding.
  - Burst end with the FIFO empty: set stray_err (sticky until reset) and take no other action.
- Simultaneous push (SIZE) and pop (tb_done) in one cycle: outstanding is unchanged and FIFO ordering is preserved.
- A push is never attempted when full, guaranteed by the credit gate in IDLE.
- Back-pressure from the coder stack's internal FIFOs is not visible to this block. The MAX_OUT credit is the only flow control.

Test Plan:
1. Reset, then descriptor 40 at cycle N → C = 1; cs_wreq_size at N+2 with cs_tb_size = 40. 40 cs_wreq_data strobes mirror up_bit. One out_valid burst → tb_done once; outstanding goes 1 → 0.
2. Descriptor 20000 → C = 4 (4 CALC cycles, cs_wreq_size at N+5). tb_done only after the 4th burst end; no tb_done after bursts 1–3.
3. Credit limit: two TBs of 6121 (C = 2) are admitted. A third descriptor sees up_size_ready = 0 until the first TB's 2nd burst end, then is accepted the next cycle.
4. Rejection: descriptor 39 and descriptor 60001 → tb_err pulse each; outstanding stays 0; up_bit_ready never rises.
5. Out_valid burst ending while idle with outstanding = 0 → stray_err = 1 and held. A later legal TB still completes normally.
6. Assert reset during DATA of a 1000-bit TB after 500 bits → all outputs 0 immediately. After release, a new 40-bit TB completes with exactly one tb_done.

Source files
------------

// File: rtl/coder_tb_scheduler.sv
// coder_tb_scheduler
//   Admission controller and sequencer for the channel-coder stack
//   (segmentation -> interleaver -> turbo encoder). It accepts a TB size
//   descriptor, computes the code-block count C, writes the size to the stack,
//   then passes the TB bits through. The number of TBs in flight is limited
//   by a MAX_OUT credit. Completion is tracked by counting the encoder's
//   out_valid bursts against a FIFO of per-TB block counts.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   up_size_*         size descriptor handshake from upstream (16-bit size)
//   up_bit_*          serial TB data handshake from upstream
//   cs_tb_size        registered TB size to the coder stack
//   cs_wreq_size      one-cycle size write strobe
//   cs_tb_in          data bit to the coder stack (valid with cs_wreq_data)
//   cs_wreq_data      data write strobe
//   cs_out_valid      encoder output valid, one burst per code block
//   tb_done           pulse: oldest TB has emitted all its code blocks
//   tb_err            pulse: descriptor rejected (size out of range)
//   stray_err         sticky: burst ended with no TB outstanding
//   outstanding       TBs currently in flight
//   busy              admission FSM active or TBs still in flight
module coder_tb_scheduler #(
    parameter int MAX_OUT = 2,
    parameter int MIN_TB  = 40,
    parameter int MAX_TB  = 60000,
    parameter int CB_MAX  = 6144,
    parameter int CB_PAY  = 6120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up_size_valid,
    input  logic [15:0] up_size,
    output logic        up_size_ready,
    input  logic        up_bit,
    input  logic        up_bit_valid,
    output logic        up_bit_ready,
    output logic [15:0] cs_tb_size,
    output logic        cs_wreq_size,
    output logic        cs_tb_in,
    output logic        cs_wreq_data,
    input  logic        cs_out_valid,
    output logic        tb_done,
    output logic        tb_err,
    output logic        stray_err,
    output logic [1:0]  outstanding,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, SIZE, DATA} state_t;

    localparam logic [1:0]  MAX_OUT_W = 2'(MAX_OUT);
    localparam logic [15:0] MIN_TB_W  = 16'(MIN_TB);
    localparam logic [15:0] MAX_TB_W  = 16'(MAX_TB);
    localparam logic [16:0] CB_MAX_W  = 17'(CB_MAX);
    localparam logic [16:0] CB_PAY_W  = 17'(CB_PAY);

    state_t      state;
    logic [15:0] size_q;
    logic [16:0] rem_q;      // remaining bits of B during CALC
    logic [3:0]  calc_cnt;   // CALC cycles elapsed
    logic [3:0]  c_q;        // code-block count of the TB being admitted
    logic [15:0] bit_cnt;
    logic [3:0]  blk_cnt;    // bursts seen for the head TB
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [3:0]  fifo_mem [4];
    logic        ov_p1;

    logic        size_hs;
    logic        bit_hs;
    logic        last_bit;
    logic        burst_end;
    logic        push;
    logic        pop;
    logic        calc_done;
    logic [1:0]  out_nxt;

    function automatic logic size_legal(input logic [15:0] s);
        return (s >= MIN_TB_W) && (s <= MAX_TB_W);
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == MAX_OUT_W - 2'd1) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        size_hs   = (state == IDLE) && up_size_valid && up_size_ready;
        bit_hs    = (state == DATA) && up_bit_valid;
        last_bit  = bit_hs && (bit_cnt == 16'd1);
        burst_end = ov_p1 && !cs_out_valid;
        push      = (state == SIZE);
        // The FIFO holds exactly the outstanding TBs, so outstanding != 0 means non-empty.
        pop       = burst_end && (outstanding != 2'd0) && ((blk_cnt + 4'd1) == fifo_mem[rd_ptr]);
        out_nxt   = outstanding + {1'b0, push} - {1'b0, pop};
        // A single block fits when B <= CB_MAX; otherwise one block per CB_PAY bits, rounded up.
        calc_done = ((calc_cnt == 4'd0) && (rem_q <= CB_MAX_W)) || (rem_q <= CB_PAY_W);
    end

    assign up_bit_ready = (state == DATA);
    assign cs_wreq_data = bit_hs;
    assign cs_tb_in     = (state == DATA) && up_bit;
    assign cs_wreq_size = (state == SIZE);
    assign cs_tb_size   = size_q;
    assign busy         = (state != IDLE) || (outstanding != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= c_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            size_q        <= '0;
            rem_q         <= '0;
            calc_cnt      <= '0;
            c_q           <= '0;
            bit_cnt       <= '0;
            blk_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ov_p1         <= 1'b0;
            outstanding   <= '0;
            up_size_ready <= 1'b0;
            tb_done       <= 1'b0;
            tb_err        <= 1'b0;
            stray_err     <= 1'b0;
        end else begin
            // ---- completion stage p1: registered out_valid, burst-end detect ----
            ov_p1       <= cs_out_valid;
            tb_done     <= pop;
            tb_err      <= 1'b0;
            outstanding <= out_nxt;
            if (burst_end) begin
                if (outstanding == 2'd0) begin
                    stray_err <= 1'b1;
                end else begin
                    blk_cnt <= pop ? 4'd0 : blk_cnt + 4'd1;
                end
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end

            // up_size_ready is registered from next state / next credit count.
            case (state)
                IDLE: begin
                    up_size_ready <= (out_nxt < MAX_OUT_W);
                    if (size_hs) begin
                        if (!size_legal(up_size)) begin
                            tb_err <= 1'b1;
                        end else begin
                            size_q        <= up_size;
                            rem_q         <= {1'b0, up_size} + 17'd24;
                            calc_cnt      <= '0;
                            up_size_ready <= 1'b0;
                            state         <= CALC;
                        end
                    end
                end
                CALC: begin
                    up_size_ready <= 1'b0;
                    calc_cnt      <= calc_cnt + 4'd1;
                    if (calc_done) begin
                        c_q   <= calc_cnt + 4'd1;
                        state <= SIZE;
                    end else begin
                        rem_q <= rem_q - CB_PAY_W;
                    end
                end
                SIZE: begin
                    up_size_ready <= 1'b0;
                    bit_cnt       <= size_q;
                    state         <= DATA;
                end
                DATA: begin
                    up_size_ready <= 1'b0;
                    if (bit_hs) begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                    if (last_bit) begin
                        up_size_ready <= (out_nxt < MAX_OUT_W);
                        state         <= IDLE;
                    end
                end
                default: begin
                    up_size_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coder_tb_scheduler.sv
// tb_coder_tb_scheduler
//   Directed bench for coder_tb_scheduler. Expected sizes and bits are queued
//   as stimulus is driven and checked when the DUT strobes them out; latency,
//   credit, completion, rejection, stray-burst and reset behaviour are checked
//   against values derived from the block's contract.
module tb_coder_tb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_size_valid;
    logic [15:0] up_size;
    logic        up_size_ready;
    logic        up_bit;
    logic        up_bit_valid;
    logic        up_bit_ready;
    logic [15:0] cs_tb_size;
    logic        cs_wreq_size;
    logic        cs_tb_in;
    logic        cs_wreq_data;
    logic        cs_out_valid;
    logic        tb_done;
    logic        tb_err;
    logic        stray_err;
    logic [1:0]  outstanding;
    logic        busy;

    coder_tb_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .up_size_valid (up_size_valid),
        .up_size       (up_size),
        .up_size_ready (up_size_ready),
        .up_bit        (up_bit),
        .up_bit_valid  (up_bit_valid),
        .up_bit_ready  (up_bit_ready),
        .cs_tb_size    (cs_tb_size),
        .cs_wreq_size  (cs_wreq_size),
        .cs_tb_in      (cs_tb_in),
        .cs_wreq_data  (cs_wreq_data),
        .cs_out_valid  (cs_out_valid),
        .tb_done       (tb_done),
        .tb_err        (tb_err),
        .stray_err     (stray_err),
        .outstanding   (outstanding),
        .busy          (busy)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int dstrb_cnt = 0;
    int wsz_cyc = -1;
    int hs_cyc = -1;
    int err_cyc = -1;
    bit ubr_seen = 1'b0;
    logic [15:0] size_q [$];
    logic        bit_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({up_size_ready, up_bit_ready, cs_tb_size, cs_wreq_size, cs_tb_in,
                    cs_wreq_data, tb_done, tb_err, stray_err, outstanding, busy});
    endfunction

    // Cycle counter: value during a cycle labels that cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        logic [15:0] es;
        logic        eb;
        forever begin
            @(negedge clk);
            if (tb_done) done_cnt++;
            if (tb_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (up_bit_ready) ubr_seen = 1'b1;
            if (up_size_valid && up_size_ready) hs_cyc = cyc;
            if (cs_wreq_size) begin
                wsz_cyc = cyc;
                if (size_q.size() == 0) begin
                    check("size_unexpected", 32'(cs_wreq_size), 32'd0);
                end else begin
                    es = size_q.pop_front();
                    check("cs_tb_size", 32'(cs_tb_size), 32'(es));
                end
            end
            if (cs_wreq_data) begin
                dstrb_cnt++;
                if (bit_q.size() == 0) begin
                    check("bit_unexpected", 32'(cs_wreq_data), 32'd0);
                end else begin
                    eb = bit_q.pop_front();
                    check("cs_tb_in", 32'(cs_tb_in), 32'(eb));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input logic [15:0] sz, input bit legal, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        up_size = sz;
        up_size_valid = 1'b1;
        if (legal) size_q.push_back(sz);
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (up_size_ready) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        up_size_valid = 1'b0;
        check("desc_accept", 32'(got), 32'd1);
    endtask

    task automatic send_bits(input int n, input bit stall);
        bit rdy;
        logic b;
        rdy = 1'b0;
        for (int k = 0; k < 50 && !rdy; k++) begin
            if (up_bit_ready) rdy = 1'b1;
            else tick();
        end
        check("bit_ready_wait", 32'(rdy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (stall && (i % 8 == 3)) begin
                up_bit_valid = 1'b0;
                tick();
            end
            b = 1'($urandom_range(1));
            up_bit = b;
            up_bit_valid = 1'b1;
            bit_q.push_back(b);
            tick();
        end
        up_bit_valid = 1'b0;
    endtask

    task automatic burst(input int len, output int end_cyc);
        tick();
        cs_out_valid = 1'b1;
        repeat (len) tick();
        cs_out_valid = 1'b0;
        end_cyc = cyc;
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, e, d0, s0, e0;
        reset = 1'b0;
        up_size_valid = 1'b0;
        up_size = '0;
        up_bit = 1'b0;
        up_bit_valid = 1'b0;
        cs_out_valid = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        tick();

        // 1: minimum TB, C = 1
        d0 = done_cnt;
        s0 = dstrb_cnt;
        send_desc(16'd40, 1'b1, acc);
        send_bits(40, 1'b1);
        check("t1_wreq_size_latency", 32'(wsz_cyc), 32'(acc + 2));
        check("t1_data_strobes", 32'(dstrb_cnt - s0), 32'd40);
        check("t1_outstanding_1", 32'(outstanding), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        burst(5, e);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_outstanding_0", 32'(outstanding), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: 20000 bits, C = 4
        d0 = done_cnt;
        send_desc(16'd20000, 1'b1, acc);
        send_bits(20000, 1'b0);
        check("t2_wreq_size_latency", 32'(wsz_cyc), 32'(acc + 5));
        for (int k = 0; k < 3; k++) begin
            burst(4, e);
            check("t2_no_early_done", 32'(done_cnt - d0), 32'd0);
        end
        burst(4, e);
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_outstanding", 32'(outstanding), 32'd0);

        // 3: credit limit with two C = 2 TBs in flight
        send_desc(16'd6121, 1'b1, acc);
        send_bits(6121, 1'b0);
        check("t3_wreq_size_latency", 32'(wsz_cyc), 32'(acc + 3));
        send_desc(16'd6121, 1'b1, acc_b);
        send_bits(6121, 1'b0);
        check("t3_outstanding_full", 32'(outstanding), 32'd2);
        hs_cyc = -1;
        d0 = done_cnt;
        up_size = 16'd6121;
        up_size_valid = 1'b1;
        size_q.push_back(16'd6121);
        repeat (5) tick();
        check("t3_ready_blocked", 32'(up_size_ready), 32'd0);
        burst(3, e);
        check("t3_no_done_burst1", 32'(done_cnt - d0), 32'd0);
        check("t3_still_blocked", 32'(up_size_ready), 32'd0);
        burst(3, e);
        up_size_valid = 1'b0;
        check("t3_accept_after_credit", 32'(hs_cyc), 32'(e + 1));
        check("t3_done_first", 32'(done_cnt - d0), 32'd1);
        send_bits(6121, 1'b0);
        check("t3_third_wreq_latency", 32'(wsz_cyc), 32'(hs_cyc + 3));
        check("t3_outstanding_refill", 32'(outstanding), 32'd2);
        repeat (4) burst(2, e);
        check("t3_all_done", 32'(done_cnt - d0), 32'd3);
        check("t3_outstanding_0", 32'(outstanding), 32'd0);

        // 4: rejected descriptors
        e0 = err_cnt;
        ubr_seen = 1'b0;
        send_desc(16'd39, 1'b0, acc);
        tick();
        check("t4_err_39", 32'(err_cnt - e0), 32'd1);
        check("t4_err_39_timing", 32'(err_cyc), 32'(acc + 1));
        send_desc(16'd60001, 1'b0, acc);
        tick();
        check("t4_err_60001", 32'(err_cnt - e0), 32'd2);
        check("t4_err_60001_timing", 32'(err_cyc), 32'(acc + 1));
        check("t4_outstanding", 32'(outstanding), 32'd0);
        check("t4_bit_ready_never", 32'(ubr_seen), 32'd0);
        check("t4_size_ready", 32'(up_size_ready), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // 5: stray burst while idle
        d0 = done_cnt;
        check("t5_stray_before", 32'(stray_err), 32'd0);
        burst(3, e);
        check("t5_stray_set", 32'(stray_err), 32'd1);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        repeat (5) tick();
        check("t5_stray_held", 32'(stray_err), 32'd1);
        send_desc(16'd40, 1'b1, acc);
        send_bits(40, 1'b0);
        burst(2, e);
        check("t5_legal_done", 32'(done_cnt - d0), 32'd1);
        check("t5_stray_still", 32'(stray_err), 32'd1);
        check("t5_outstanding", 32'(outstanding), 32'd0);

        // 6: reset in the middle of DATA
        send_desc(16'd1000, 1'b1, acc);
        send_bits(500, 1'b0);
        check("t6_in_data", 32'(up_bit_ready), 32'd1);
        check("t6_outstanding", 32'(outstanding), 32'd1);
        d0 = done_cnt;
        e0 = err_cnt;
        up_bit = 1'b1;
        up_bit_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("t6_reset_outputs", all_outs(), 32'd0);
        up_bit_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("t6_no_done_on_reset", 32'(done_cnt - d0), 32'd0);
        check("t6_no_err_on_reset", 32'(err_cnt - e0), 32'd0);
        send_desc(16'd40, 1'b1, acc);
        send_bits(40, 1'b0);
        check("t6_wreq_size_latency", 32'(wsz_cyc), 32'(acc + 2));
        burst(3, e);
        repeat (3) tick();
        check("t6_single_done", 32'(done_cnt - d0), 32'd1);
        check("t6_outstanding", 32'(outstanding), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        check("size_queue_drained", 32'(size_q.size()), 32'd0);
        check("bit_queue_drained", 32'(bit_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
